// File: rtl/fill_pkg.sv
// Shared types and screen geometry for the span fill controller.
package fill_pkg;

  // Screen and line-buffer geometry
  localparam int SCREEN_W        = 256;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int ROW_STRIDE      = 768;
  localparam int LINE_ROWS       = 64;
  localparam int LINE_COLS       = 64;
  localparam int ROW_W           = 6;
  localparam int COL_W           = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND,
    ST_SCAN,
    ST_WRITE,
    ST_DONE
  } fill_state_t;

  // Byte address of pixel (x0+col, y0+row) in a 24-bit framebuffer,
  // wrapping modulo 2^32.
  function automatic logic [31:0] span_addr(
    input logic [31:0]      base,
    input logic [7:0]       y0,
    input logic [ROW_W-1:0] row,
    input logic [7:0]       x0,
    input logic [COL_W-1:0] col
  );
    logic [31:0] y;
    logic [31:0] x;
    y = 32'(y0) + 32'(row);
    x = 32'(x0) + 32'(col);
    return base + y * 32'(ROW_STRIDE) + x * 32'(BYTES_PER_PIXEL);
  endfunction

endpackage

// File: rtl/span_finder.sv
// Lowest/highest set-bit priority encoders over one line-buffer row.
module span_finder
  import fill_pkg::*;
(
  input  logic [LINE_COLS-1:0] row_bits,
  output logic [COL_W-1:0]     x0,
  output logic [COL_W-1:0]     x1,
  output logic                 any
);

  // Descending scan leaves the lowest set bit; ascending leaves the highest.
  always_comb begin
    x0 = '0;
    x1 = '0;
    for (int j = LINE_COLS - 1; j >= 0; j--) begin
      if (row_bits[COL_W'(j)]) x0 = COL_W'(j);
    end
    for (int j = 0; j < LINE_COLS; j++) begin
      if (row_bits[COL_W'(j)]) x1 = COL_W'(j);
    end
  end

  assign any = |row_bits;

endmodule

// File: rtl/fill_controller.sv
// Walks the 64-row line buffer below a found corner and issues one span
// write per non-empty, on-screen row.
module fill_controller
  import fill_pkg::*;
#(
  parameter logic [31:0] LAYER0_BASE = 32'h0000_0000,
  parameter logic [31:0] LAYER1_BASE = 32'h0003_0000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 layer_num,
  output logic                 find_flag,
  input  logic                 find_done,
  input  logic [7:0]           xmin,
  input  logic [7:0]           ymin,
  output logic [ROW_W-1:0]     row_idx,
  input  logic [LINE_COLS-1:0] row_bits,
  output logic                 wr_req,
  input  logic                 wr_ack,
  output logic [31:0]          wr_addr,
  output logic [COL_W-1:0]     wr_x0,
  output logic [COL_W-1:0]     wr_x1,
  output logic                 busy,
  output logic                 done
);

  fill_state_t      state_reg, state_next;
  logic             layer_reg, layer_next;
  logic [7:0]       xmin_reg,  xmin_next;
  logic [7:0]       ymin_reg,  ymin_next;
  logic [ROW_W-1:0] row_reg,   row_next;
  logic [COL_W-1:0] x0_reg,    x0_next;
  logic [COL_W-1:0] x1_reg,    x1_next;
  logic [31:0]      addr_reg,  addr_next;

  logic [COL_W-1:0] span_x0;
  logic [COL_W-1:0] span_x1;
  logic             span_any;
  logic [8:0]       row_y;
  logic             row_clipped;
  logic             last_row;
  logic [31:0]      layer_base;

  span_finder u_span_finder (
    .row_bits (row_bits),
    .x0       (span_x0),
    .x1       (span_x1),
    .any      (span_any)
  );

  // Screen row of the current line-buffer row; bit 8 means off the bottom.
  assign row_y       = {1'b0, ymin_reg} + {3'b000, row_reg};
  assign row_clipped = row_y[8];
  assign last_row    = (row_reg == ROW_W'(LINE_ROWS - 1));
  assign layer_base  = layer_reg ? LAYER1_BASE : LAYER0_BASE;

  // State and latched span registers; reset clears every visible output.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      layer_reg <= 1'b0;
      xmin_reg  <= '0;
      ymin_reg  <= '0;
      row_reg   <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      layer_reg <= layer_next;
      xmin_reg  <= xmin_next;
      ymin_reg  <= ymin_next;
      row_reg   <= row_next;
      x0_reg    <= x0_next;
      x1_reg    <= x1_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state and Moore outputs; the address is latched on entry to WRITE
  // so it stays stable for the whole handshake.
  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    xmin_next  = xmin_reg;
    ymin_next  = ymin_reg;
    row_next   = row_reg;
    x0_next    = x0_reg;
    x1_next    = x1_reg;
    addr_next  = addr_reg;
    find_flag  = 1'b0;
    wr_req     = 1'b0;
    done       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          layer_next = layer_num;
          state_next = ST_FIND;
        end
      end
      ST_FIND: begin
        find_flag = 1'b1;
        if (find_done) begin
          xmin_next  = xmin;
          ymin_next  = ymin;
          row_next   = '0;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!span_any || row_clipped) begin
          if (last_row) state_next = ST_DONE;
          else          row_next   = row_reg + 1'b1;
        end else begin
          x0_next    = span_x0;
          x1_next    = span_x1;
          addr_next  = span_addr(layer_base, ymin_reg, row_reg, xmin_reg, span_x0);
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          if (last_row) begin
            state_next = ST_DONE;
          end else begin
            row_next   = row_reg + 1'b1;
            state_next = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy    = (state_reg != ST_IDLE);
  assign row_idx = row_reg;
  assign wr_addr = addr_reg;
  assign wr_x0   = x0_reg;
  assign wr_x1   = x1_reg;

endmodule

// File: tb/tb_fill_controller.sv
// Table-driven, directed and randomized checks for fill_controller against a
// row-by-row behavioural model of the fill.
`timescale 1ns/1ps
module tb_fill_controller;
  import fill_pkg::*;

  localparam logic [31:0] L0_BASE = 32'h0000_0000;
  localparam logic [31:0] L1_BASE = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        layer_num = 1'b0;
  logic        find_flag;
  logic        find_done = 1'b0;
  logic [7:0]  xmin = 8'd0;
  logic [7:0]  ymin = 8'd0;
  logic [5:0]  row_idx;
  logic [63:0] row_bits;
  logic        wr_req;
  logic        wr_ack = 1'b0;
  logic [31:0] wr_addr;
  logic [5:0]  wr_x0;
  logic [5:0]  wr_x1;
  logic        busy;
  logic        done;

  logic [63:0] line_buf [64];
  assign row_bits = line_buf[row_idx];

  always #5 clk = ~clk;

  fill_controller #(
    .LAYER0_BASE (L0_BASE),
    .LAYER1_BASE (L1_BASE)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .layer_num (layer_num),
    .find_flag (find_flag),
    .find_done (find_done),
    .xmin      (xmin),
    .ymin      (ymin),
    .row_idx   (row_idx),
    .row_bits  (row_bits),
    .wr_req    (wr_req),
    .wr_ack    (wr_ack),
    .wr_addr   (wr_addr),
    .wr_x0     (wr_x0),
    .wr_x1     (wr_x1),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  x0;
    logic [5:0]  x1;
  } span_t;
  span_t exp_q[$];

  // Reference: every on-screen, non-empty row yields one span from its
  // lowest to highest set pixel.
  function automatic void model_fill(input logic lyr, input logic [7:0] xm, input logic [7:0] ym);
    exp_q.delete();
    for (int r = 0; r < 64; r++) begin
      int lo;
      int hi;
      lo = -1;
      hi = -1;
      if (int'(ym) + r <= 255) begin
        for (int j = 0; j < 64; j++) begin
          if (line_buf[6'(r)][6'(j)]) begin
            if (lo < 0) lo = j;
            hi = j;
          end
        end
        if (lo >= 0) begin
          span_t s;
          s.addr = (lyr ? L1_BASE : L0_BASE) + 32'((int'(ym) + r) * 768 + (int'(xm) + lo) * 3);
          s.x0   = 6'(lo);
          s.x1   = 6'(hi);
          exp_q.push_back(s);
        end
      end
    end
  endfunction

  // Runs one fill cycle by cycle, answering find/write handshakes with the
  // given latencies and checking every write against the model.
  task automatic run_fill(input logic lyr, input logic [7:0] xm, input logic [7:0] ym,
                          input int find_lat, input int ack_lat,
                          output int n_wr, output logic [31:0] addr0,
                          output logic [5:0] x0_first, output logic [5:0] x1_first,
                          output int done_cyc, output int max_req);
    int    fcnt;
    int    acnt;
    int    req_len;
    int    widx;
    int    exp_done;
    bit    finished;
    span_t held;
    model_fill(lyr, xm, ym);
    exp_done = 2 + find_lat + 64 + exp_q.size() * (ack_lat + 1);
    n_wr = 0; addr0 = '0; x0_first = '0; x1_first = '0; done_cyc = -1; max_req = 0;
    fcnt = 0; acnt = 0; req_len = 0; widx = 0; finished = 0;
    held = '{default: '0};
    xmin = xm;
    ymin = ym;
    @(negedge clk);
    start = 1'b1; layer_num = lyr; find_done = 1'b0; wr_ack = 1'b0;
    for (int cyc = 1; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      layer_num = ~lyr;
      find_done = 1'b0;
      wr_ack    = wr_req ? 1'b0 : 1'($urandom_range(0, 1));
      check("busy", 32'(busy), 32'd1);
      check("find_flag", 32'(find_flag), 32'(cyc <= 1 + find_lat));
      if (find_flag) begin
        if (fcnt == find_lat) find_done = 1'b1;
        fcnt++;
      end
      if (wr_req) begin
        if (req_len == 0) begin
          n_wr++;
          if (widx < exp_q.size()) held = exp_q[widx];
          check("write_count_live", 32'(n_wr), 32'(exp_q.size() >= n_wr ? n_wr : exp_q.size()));
          check("wr_addr", wr_addr, held.addr);
          check("wr_x0", 32'(wr_x0), 32'(held.x0));
          check("wr_x1", 32'(wr_x1), 32'(held.x1));
          if (n_wr == 1) begin
            addr0 = wr_addr; x0_first = wr_x0; x1_first = wr_x1;
          end
        end else begin
          check("wr_addr_stable", wr_addr, held.addr);
          check("wr_x0_stable", 32'(wr_x0), 32'(held.x0));
          check("wr_x1_stable", 32'(wr_x1), 32'(held.x1));
        end
        req_len++;
        if (req_len > max_req) max_req = req_len;
        if (acnt == ack_lat) begin
          wr_ack = 1'b1; acnt = 0; req_len = 0; widx++;
        end else begin
          acnt++;
        end
      end
      if (done) begin
        finished = 1;
        done_cyc = cyc;
      end
    end
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("write_count", 32'(n_wr), 32'(exp_q.size()));
    @(negedge clk);
    start = 1'b0; wr_ack = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    $display("fill layer=%0d xmin=%0d ymin=%0d writes=%0d done_cycle=%0d", lyr, xm, ym, n_wr, done_cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_find_flag"}, 32'(find_flag), 32'd0);
    check({tag, "_wr_req"},    32'(wr_req),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_row_idx"},   32'(row_idx),   32'd0);
    check({tag, "_wr_addr"},   wr_addr,        32'd0);
    check({tag, "_wr_x0"},     32'(wr_x0),     32'd0);
    check({tag, "_wr_x1"},     32'(wr_x1),     32'd0);
  endtask

  typedef struct {
    logic        lyr;
    logic [7:0]  xm;
    logic [7:0]  ym;
    int          row;
    logic [63:0] bits;
    bit          all_rows;
    int          find_lat;
    int          ack_lat;
    int          exp_wr;
    logic [31:0] exp_addr;
    logic [5:0]  exp_x0;
    logic [5:0]  exp_x1;
    int          exp_done;
    int          exp_req;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int          n_wr;
    int          dc;
    int          mr;
    int          k;
    logic [31:0] a0;
    logic [5:0]  x0v;
    logic [5:0]  x1v;

    vecs[0] = '{1'b0, 8'd10,  8'd20,  0, 64'h0000_0000_0000_00F0, 1'b0, 0, 0, 1, 32'd15402,  6'd4,  6'd7,  67, 1};
    vecs[1] = '{1'b1, 8'd0,   8'd0,   0, 64'h0,                   1'b0, 0, 0, 0, 32'd0,      6'd0,  6'd0,  66, 0};
    vecs[2] = '{1'b0, 8'd0,   8'd0,   5, 64'h8000_0000_0000_0000, 1'b0, 0, 3, 1, 32'd4029,   6'd63, 6'd63, 70, 4};
    vecs[3] = '{1'b0, 8'd0,   8'd250, 0, 64'h1,                   1'b1, 0, 0, 6, 32'd192000, 6'd0,  6'd0,  72, 1};
    vecs[4] = '{1'b1, 8'd255, 8'd0,  63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 0, 1, 32'd245757, 6'd0,  6'd63, 69, 1};

    for (int r = 0; r < 64; r++) line_buf[r] = 64'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("in_reset");
    n_rst = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < 64; r++) line_buf[r] = vecs[i].all_rows ? vecs[i].bits : 64'd0;
      if (!vecs[i].all_rows) line_buf[6'(vecs[i].row)] = vecs[i].bits;
      run_fill(vecs[i].lyr, vecs[i].xm, vecs[i].ym, vecs[i].find_lat, vecs[i].ack_lat,
               n_wr, a0, x0v, x1v, dc, mr);
      check("tbl_writes", 32'(n_wr), 32'(vecs[i].exp_wr));
      check("tbl_done", 32'(dc), 32'(vecs[i].exp_done));
      check("tbl_req_len", 32'(mr), 32'(vecs[i].exp_req));
      if (vecs[i].exp_wr > 0) begin
        check("tbl_addr", a0, vecs[i].exp_addr);
        check("tbl_x0", 32'(x0v), 32'(vecs[i].exp_x0));
        check("tbl_x1", 32'(x1v), 32'(vecs[i].exp_x1));
      end
    end

    // Reset in the middle of a write handshake
    for (int r = 0; r < 64; r++) line_buf[r] = 64'd0;
    line_buf[3] = 64'h0000_0100_0000_0000;
    xmin = 8'd5; ymin = 8'd7;
    @(negedge clk);
    start = 1'b1; layer_num = 1'b1;
    @(negedge clk);
    start = 1'b0; find_done = 1'b1;
    k = 0;
    while (!wr_req && k < 100) begin
      @(negedge clk);
      find_done = 1'b0;
      k++;
    end
    check("rst_reached_write", 32'(wr_req), 32'd1);
    #2 n_rst = 1'b0;
    #1 check_all_zero("mid_write_reset");
    $display("reset asserted during write, wr_req=%0d busy=%0d", wr_req, busy);
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      wr_ack = 1'b1;
      check("no_retry_wr_req", 32'(wr_req), 32'd0);
      check("no_retry_busy", 32'(busy), 32'd0);
    end
    wr_ack = 1'b0;
    run_fill(1'b0, 8'd5, 8'd7, 1, 1, n_wr, a0, x0v, x1v, dc, mr);
    check("post_reset_writes", 32'(n_wr), 32'd1);
    check("post_reset_addr", a0, 32'((7 + 3) * 768 + (5 + 40) * 3));

    // Randomized fills
    for (int t = 0; t < 20; t++) begin
      for (int r = 0; r < 64; r++) begin
        case ($urandom_range(0, 3))
          0:       line_buf[r] = 64'd0;
          1:       line_buf[r] = 64'd1 << $urandom_range(0, 63);
          2:       line_buf[r] = {$urandom, $urandom};
          default: line_buf[r] = 64'd0;
        endcase
      end
      run_fill(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               8'(($urandom_range(0, 1) == 1) ? $urandom_range(180, 255) : $urandom_range(0, 255)),
               $urandom_range(0, 3), $urandom_range(0, 3),
               n_wr, a0, x0v, x1v, dc, mr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
